// File: rtl/clk_int_div_dyn.sv
// Runtime-programmable integer clock divider with a registered divided clock, a period-start
// enable pulse and a valid/ready ratio update that only takes effect at a period boundary.
module clk_int_div_dyn #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o,
    output logic                 clk_en_o,
    output logic                 active_o
);

    typedef enum logic [0:0] {StPark, StRun} state_e;

    localparam logic [DIV_WIDTH-1:0] ResetDiv =
        (DEFAULT_DIV < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DEFAULT_DIV);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : v;
    endfunction

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cur_div_q, cur_div_d;
    logic [DIV_WIDTH-1:0]   pend_div_q, pend_div_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   clk_q, clk_d;
    logic                   clk_en_q, clk_en_d;

    logic                   terminal;
    logic                   apply;
    logic                   xfer;
    logic [DIV_WIDTH-1:0]   next_div;
    logic [DIV_WIDTH-1:0]   high_len;
    logic [DIV_WIDTH-1:0]   cnt_inc;

    assign terminal = (cnt_q == cur_div_q - DIV_WIDTH'(1));
    assign apply    = pend_vld_q && ((state_q == StPark) || terminal);
    assign xfer     = div_valid_i && !pend_vld_q;
    assign next_div = apply ? pend_div_q : cur_div_q;
    assign cnt_inc  = cnt_q + DIV_WIDTH'(1);
    // ceil(N/2) without widening: N=2^W-1 would overflow N+1.
    assign high_len = (cur_div_q >> 1) + DIV_WIDTH'(cur_div_q[0]);

    always_comb begin
        state_d    = state_q;
        cur_div_d  = next_div;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        clk_d      = clk_q;
        clk_en_d   = 1'b0;

        // xfer needs !pend_vld_q and apply needs pend_vld_q, so at most one fires.
        if (xfer) begin
            pend_div_d = clamp_div(div_i);
            pend_vld_d = 1'b1;
        end
        if (apply) begin
            pend_vld_d = 1'b0;
        end

        unique case (state_q)
            StPark: begin
                cnt_d = next_div - DIV_WIDTH'(1);
                clk_d = 1'b0;
                if (en_i) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    clk_d    = 1'b1;
                    clk_en_d = 1'b1;
                end
            end
            StRun: begin
                if (terminal) begin
                    if (en_i) begin
                        cnt_d    = '0;
                        clk_d    = 1'b1;
                        clk_en_d = 1'b1;
                    end else begin
                        state_d = StPark;
                        cnt_d   = next_div - DIV_WIDTH'(1);
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StPark;
            cur_div_q  <= ResetDiv;
            pend_div_q <= ResetDiv;
            pend_vld_q <= 1'b0;
            cnt_q      <= ResetDiv - DIV_WIDTH'(1);
            clk_q      <= 1'b0;
            clk_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            clk_en_q   <= clk_en_d;
        end
    end

    assign div_ready_o = !pend_vld_q;
    assign clk_o       = clk_q;
    assign clk_en_o    = clk_en_q;
    assign active_o    = (state_q == StRun);

endmodule
